// File: rtl/tree_space_pkg.sv
// Shared constants, types and helpers for the tree node-address allocator.
package tree_space_pkg;

  localparam int ROOT_ADDR          = 0;
  localparam int DEFAULT_ADDR_WIDTH = 16;

  typedef logic [DEFAULT_ADDR_WIDTH-1:0] node_addr_t;

  // Bits needed to hold a count that can reach n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tsa_free_fifo.sv
// First-word-fall-through recycle FIFO holding released node addresses.
// The head is read straight out of the storage flops, so a pushed word
// becomes visible at the head on the cycle after the push.
module tsa_free_fifo
  import tree_space_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head,
  output logic                        empty,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;

  // Pointers wrap by compare-and-clear so any DEPTH works, not just powers of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage write; contents need no reset because empty gates the head.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps the depth.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/tree_space_allocator.sv
// Node-address allocator for the tree RAM. Recycled addresses are handed
// out first; otherwise a saturating bump pointer supplies fresh ones.
module tree_space_allocator
  import tree_space_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int NODE_COUNT         = 256,
  parameter int ALMOST_FULL_THRESH = NODE_COUNT - 2
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      tree_mgt_req_valid,
  output logic                      tree_mgt_req_ready,
  output logic [RAM_ADDR_WIDTH-1:0] tree_mgt_req_addr,
  input  logic                      tree_mgt_free_valid,
  output logic                      tree_mgt_free_ready,
  input  logic [RAM_ADDR_WIDTH-1:0] tree_mgt_free_addr,
  output logic [RAM_ADDR_WIDTH:0]   tree_mgt_used_count,
  output logic                      tree_mgt_full,
  output logic                      tree_mgt_almost_full,
  output logic                      tree_mgt_error
);

  localparam int AW = RAM_ADDR_WIDTH;
  localparam int UW = RAM_ADDR_WIDTH + 1;
  localparam int CW = cnt_width(NODE_COUNT);

  logic          en_q;
  logic [UW-1:0] bump_q;
  logic [UW-1:0] used_q;
  logic [UW-1:0] used_next;
  logic [AW-1:0] last_addr_q;
  logic          full_q;
  logic          almost_full_q;
  logic          error_q;

  logic          fifo_empty;
  logic [AW-1:0] fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_pop;
  logic          fifo_room;

  logic          bump_avail;
  logic          alloc;
  logic          free_hs;
  logic          free_ok;
  logic          free_bad;

  tsa_free_fifo #(
    .WIDTH (AW),
    .DEPTH (NODE_COUNT)
  ) u_free_fifo (
    .aclk      (aclk),
    .areset    (areset),
    .push      (free_ok),
    .push_data (tree_mgt_free_addr),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bump_avail = (bump_q < UW'(NODE_COUNT));

  // Address source selection and handshake decode; ready never looks at valid.
  always_comb begin
    tree_mgt_req_ready = en_q && (!fifo_empty || bump_avail);
    if (!fifo_empty)     tree_mgt_req_addr = fifo_head;
    else if (bump_avail) tree_mgt_req_addr = bump_q[AW-1:0];
    else                 tree_mgt_req_addr = last_addr_q;
    alloc     = tree_mgt_req_valid && tree_mgt_req_ready;
    fifo_pop  = alloc && !fifo_empty;
    fifo_room = (fifo_count != CW'(NODE_COUNT)) || fifo_pop;
    free_hs   = tree_mgt_free_valid && en_q;
    free_ok   = free_hs && ({1'b0, tree_mgt_free_addr} < UW'(NODE_COUNT)) &&
                ((used_q != '0) || alloc) && fifo_room;
    free_bad  = free_hs && !free_ok;
  end

  // Occupancy after this cycle's allocation and release.
  always_comb begin
    used_next = used_q;
    if (alloc && !free_ok)      used_next = used_q + UW'(1);
    else if (!alloc && free_ok) used_next = used_q - UW'(1);
  end

  // Allocator state plus registered status flags derived from next occupancy.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      en_q          <= 1'b0;
      bump_q        <= '0;
      used_q        <= '0;
      last_addr_q   <= AW'(ROOT_ADDR);
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      en_q          <= 1'b1;
      if (alloc && fifo_empty) bump_q <= bump_q + UW'(1);
      used_q        <= used_next;
      last_addr_q   <= tree_mgt_req_addr;
      full_q        <= (used_next == UW'(NODE_COUNT));
      almost_full_q <= (used_next >= UW'(ALMOST_FULL_THRESH));
      if (free_bad) error_q <= 1'b1;
    end
  end

  assign tree_mgt_free_ready  = en_q;
  assign tree_mgt_used_count  = used_q;
  assign tree_mgt_full        = full_q;
  assign tree_mgt_almost_full = almost_full_q;
  assign tree_mgt_error       = error_q;

endmodule

// File: tb/tb_tree_space_allocator.sv
// Self-checking bench: directed table and sequences on a 4-node allocator,
// randomized traffic on a 5-node allocator against a queue-based model.
module tb_tree_space_allocator;

  localparam int AW = 4;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  // 4-node instance
  logic          areset4;
  logic          req_valid4;
  logic          req_ready4;
  logic [AW-1:0] req_addr4;
  logic          free_valid4;
  logic          free_ready4;
  logic [AW-1:0] free_addr4;
  logic [AW:0]   used4;
  logic          full4;
  logic          af4;
  logic          err4;

  // 5-node instance
  logic          areset5;
  logic          req_valid5;
  logic          req_ready5;
  logic [AW-1:0] req_addr5;
  logic          free_valid5;
  logic          free_ready5;
  logic [AW-1:0] free_addr5;
  logic [AW:0]   used5;
  logic          full5;
  logic          af5;
  logic          err5;

  tree_space_allocator #(.RAM_ADDR_WIDTH(AW), .NODE_COUNT(4)) dut4 (
    .aclk                 (aclk),
    .areset               (areset4),
    .tree_mgt_req_valid   (req_valid4),
    .tree_mgt_req_ready   (req_ready4),
    .tree_mgt_req_addr    (req_addr4),
    .tree_mgt_free_valid  (free_valid4),
    .tree_mgt_free_ready  (free_ready4),
    .tree_mgt_free_addr   (free_addr4),
    .tree_mgt_used_count  (used4),
    .tree_mgt_full        (full4),
    .tree_mgt_almost_full (af4),
    .tree_mgt_error       (err4)
  );

  tree_space_allocator #(.RAM_ADDR_WIDTH(AW), .NODE_COUNT(5)) dut5 (
    .aclk                 (aclk),
    .areset               (areset5),
    .tree_mgt_req_valid   (req_valid5),
    .tree_mgt_req_ready   (req_ready5),
    .tree_mgt_req_addr    (req_addr5),
    .tree_mgt_free_valid  (free_valid5),
    .tree_mgt_free_ready  (free_ready5),
    .tree_mgt_free_addr   (free_addr5),
    .tree_mgt_used_count  (used5),
    .tree_mgt_full        (full5),
    .tree_mgt_almost_full (af5),
    .tree_mgt_error       (err5)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic          rv;
    logic          fv;
    logic [AW-1:0] fa;
    logic          ready;
    logic [AW-1:0] addr;
    int            used;
    logic          full;
    logic          af;
    logic          err;
  } vec_t;

  vec_t vecs [9];

  // Stress model: recycle queue, bump counter and held-address set
  int   model_q [$];
  int   model_bump;
  int   model_last;
  int   held_cnt;
  bit   held [5];
  bit   model_err;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkReset4(input string tag);
    checkOutput({tag, " req_ready"},  req_ready4,  0);
    checkOutput({tag, " req_addr"},   req_addr4,   0);
    checkOutput({tag, " free_ready"}, free_ready4, 0);
    checkOutput({tag, " used"},       used4,       0);
    checkOutput({tag, " full"},       full4,       0);
    checkOutput({tag, " almost"},     af4,         0);
    checkOutput({tag, " error"},      err4,        0);
  endtask

  task automatic doReset4(input string tag);
    areset4     = 1'b1;
    req_valid4  = 1'b0;
    free_valid4 = 1'b0;
    free_addr4  = '0;
    @(negedge aclk);
    #1;
    checkReset4(tag);
    @(negedge aclk);
    areset4 = 1'b0;
    @(posedge aclk);
  endtask

  task automatic applyStimulus(input logic rv, input logic fv, input logic [AW-1:0] fa);
    @(negedge aclk);
    req_valid4  = rv;
    free_valid4 = fv;
    free_addr4  = fa;
    #1;
  endtask

  task automatic stepCheck4(input string tag, input logic rv, input logic fv,
                            input logic [AW-1:0] fa, input logic ready,
                            input logic [AW-1:0] addr, input int used,
                            input logic full, input logic af, input logic err);
    applyStimulus(rv, fv, fa);
    checkOutput({tag, " req_ready"},  req_ready4, ready);
    checkOutput({tag, " req_addr"},   req_addr4,  addr);
    checkOutput({tag, " free_ready"}, free_ready4, 1);
    checkOutput({tag, " used"},       used4,      used);
    checkOutput({tag, " full"},       full4,      full);
    checkOutput({tag, " almost"},     af4,        af);
    checkOutput({tag, " error"},      err4,       err);
  endtask

  initial begin
    int   pick;
    int   exp_addr;
    bit   exp_ready;
    bit   alloc;
    bit   legal;
    logic rv;
    logic fv;
    int   fa;

    areset4 = 1'b1; req_valid4 = 1'b0; free_valid4 = 1'b0; free_addr4 = '0;
    areset5 = 1'b1; req_valid5 = 1'b0; free_valid5 = 1'b0; free_addr5 = '0;

    // Fill to full, then free 2 and reallocate it
    vecs[0] = '{1'b1, 1'b0, 4'd0, 1'b1, 4'd0, 0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 4'd0, 1'b1, 4'd1, 1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 4'd0, 1'b1, 4'd2, 2, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 4'd0, 1'b1, 4'd3, 3, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 4'd0, 1'b0, 4'd3, 4, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 4'd2, 1'b0, 4'd3, 4, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 4'd0, 1'b1, 4'd2, 3, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 4'd0, 1'b1, 4'd2, 3, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd2, 4, 1'b1, 1'b1, 1'b0};

    doReset4("reset");
    for (int i = 0; i < 9; i++) begin
      stepCheck4($sformatf("vec%0d", i), vecs[i].rv, vecs[i].fv, vecs[i].fa,
                 vecs[i].ready, vecs[i].addr, vecs[i].used, vecs[i].full,
                 vecs[i].af, vecs[i].err);
    end

    // Simultaneous allocation and free, first with empty then non-empty FIFO
    doReset4("reset_b");
    stepCheck4("simul0", 1, 0, 0, 1, 0, 0, 0, 0, 0);
    stepCheck4("simul1", 1, 0, 0, 1, 1, 1, 0, 0, 0);
    stepCheck4("simul2", 1, 1, 0, 1, 2, 2, 0, 1, 0);
    stepCheck4("simul3", 1, 1, 1, 1, 0, 2, 0, 1, 0);
    stepCheck4("simul4", 0, 0, 0, 1, 1, 2, 0, 1, 0);

    // Free with nothing allocated is dropped and flags error
    doReset4("reset_c1");
    stepCheck4("emptyfree0", 0, 1, 1, 1, 0, 0, 0, 0, 0);
    stepCheck4("emptyfree1", 0, 0, 0, 1, 0, 0, 0, 0, 1);
    stepCheck4("emptyfree2", 1, 0, 0, 1, 0, 0, 0, 0, 1);
    stepCheck4("emptyfree3", 0, 0, 0, 1, 1, 1, 0, 0, 1);

    // Out-of-range free is dropped and flags error
    doReset4("reset_c2");
    stepCheck4("range0", 1, 0, 0, 1, 0, 0, 0, 0, 0);
    stepCheck4("range1", 1, 0, 0, 1, 1, 1, 0, 0, 0);
    stepCheck4("range2", 0, 1, 7, 1, 2, 2, 0, 1, 0);
    stepCheck4("range3", 0, 0, 0, 1, 2, 2, 0, 1, 1);
    stepCheck4("range4", 0, 0, 0, 1, 2, 2, 0, 1, 1);

    // Asynchronous reset in the middle of a cycle
    doReset4("reset_d");
    stepCheck4("mid0", 1, 0, 0, 1, 0, 0, 0, 0, 0);
    stepCheck4("mid1", 1, 0, 0, 1, 1, 1, 0, 0, 0);
    stepCheck4("mid2", 1, 0, 0, 1, 2, 2, 0, 1, 0);
    stepCheck4("mid3", 1, 0, 0, 1, 3, 3, 0, 1, 0);
    stepCheck4("mid4", 0, 1, 1, 0, 3, 4, 1, 1, 0);
    stepCheck4("mid5", 0, 1, 7, 1, 1, 3, 0, 1, 0);
    stepCheck4("mid6", 0, 0, 0, 1, 1, 3, 0, 1, 1);
    #2;
    areset4 = 1'b1;
    #1;
    checkReset4("async");
    @(negedge aclk);
    areset4 = 1'b0;
    @(posedge aclk);
    stepCheck4("post0", 1, 0, 0, 1, 0, 0, 0, 0, 0);
    stepCheck4("post1", 0, 0, 0, 1, 1, 1, 0, 0, 0);

    // Randomized traffic on the 5-node instance
    model_bump = 0; model_last = 0; held_cnt = 0; model_err = 1'b0;
    for (int i = 0; i < 5; i++) held[i] = 1'b0;
    @(negedge aclk);
    #1;
    checkOutput("stress reset req_ready", req_ready5, 0);
    checkOutput("stress reset used", used5, 0);
    @(negedge aclk);
    areset5 = 1'b0;
    @(posedge aclk);

    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge aclk);
      rv = 1'($urandom_range(0, 1));
      fv = 1'b0;
      fa = 0;
      if ($urandom_range(0, 1) == 1) begin
        fv = 1'b1;
        if (held_cnt > 0 && $urandom_range(0, 31) != 0) begin
          pick = $urandom_range(0, held_cnt - 1);
          for (int a = 0; a < 5; a++) begin
            if (held[a]) begin
              if (pick == 0) fa = a;
              pick--;
            end
          end
        end else if (held_cnt == 0 && $urandom_range(0, 1) == 1) begin
          fa = $urandom_range(0, 4);
          rv = 1'b0;
        end else begin
          fa = 5 + $urandom_range(0, 2);
        end
      end
      req_valid5  = rv;
      free_valid5 = fv;
      free_addr5  = AW'(fa);
      #1;

      exp_ready = (model_q.size() > 0) || (model_bump < 5);
      if (model_q.size() > 0) exp_addr = model_q[0];
      else if (model_bump < 5) exp_addr = model_bump;
      else exp_addr = model_last;

      checkOutput("stress req_ready", req_ready5, exp_ready);
      checkOutput("stress req_addr", req_addr5, exp_addr);
      checkOutput("stress used", used5, held_cnt);
      checkOutput("stress full", full5, held_cnt == 5);
      checkOutput("stress almost", af5, held_cnt >= 3);
      checkOutput("stress error", err5, model_err);
      checkOutput("stress outstanding<=5", used5 <= 5, 1);

      alloc = rv && exp_ready;
      legal = fv && (fa < 5) && (held_cnt > 0 || alloc);
      if (alloc) begin
        checkOutput("stress alloc unique",
                    (req_addr5 < 5) && !held[int'(req_addr5) % 5], 1);
        if (model_q.size() > 0) void'(model_q.pop_front());
        else model_bump++;
        held[exp_addr] = 1'b1;
        held_cnt++;
      end
      if (legal) begin
        model_q.push_back(fa);
        held[fa] = 1'b0;
        held_cnt--;
      end
      if (fv && !legal) model_err = 1'b1;
      model_last = exp_addr;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/tree_space_allocator.md
Name: tree_space_allocator

Overview:
Parametrised node-address allocator for the tree RAM. It hands out free node addresses, accepts released addresses back, and reports occupancy, full and error status. Fresh addresses come from a bump pointer; released addresses go into an internal recycle FIFO and are reused first. It sits between the tree engine's insert/delete FSMs and the node RAM.

Parameters:
RAM_ADDR_WIDTH, 16, width of node address bus in bits
NODE_COUNT, 256, number of allocatable nodes; addresses 0..NODE_COUNT-1; must be <= 2**RAM_ADDR_WIDTH and >= 2
ALMOST_FULL_THRESH, NODE_COUNT-2, used_count at or above which tree_mgt_almost_full asserts

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
tree_mgt_req_valid  in  1  requester wants an address
tree_mgt_req_ready  out  1  address available on tree_mgt_req_addr
tree_mgt_req_addr  out  RAM_ADDR_WIDTH  allocated address, valid while req_ready=1
tree_mgt_free_valid  in  1  requester releases an address
tree_mgt_free_ready  out  1  release accepted
tree_mgt_free_addr  in  RAM_ADDR_WIDTH  released address
tree_mgt_used_count  out  RAM_ADDR_WIDTH+1  number of addresses currently allocated
tree_mgt_full  out  1  used_count == NODE_COUNT
tree_mgt_almost_full  out  1  used_count >= ALMOST_FULL_THRESH
tree_mgt_error  out  1  sticky: illegal free seen; cleared only by reset

Behaviour:
- Reset (asynchronous, active-high, any time, including mid-transfer): bump pointer=0, FIFO empty, used_count=0, error=0. Outputs: req_ready=0 during reset and =1 from the first cycle after release; req_addr=0; free_ready=1 after release; full=0; almost_full=0.
- Address source:
  - FIFO non-empty: req_addr = FIFO head (recycled, priority).
  - Otherwise, bump pointer < NODE_COUNT: req_addr = bump pointer.
  - Otherwise: req_ready=0 and req_addr holds its last value.
- Handshake (valid/ready): allocation occurs in a cycle with req_valid && req_ready.
  - req_ready never depends on req_valid.
  - req_addr is stable while req_ready=1 and no handshake occurs.
  - On allocation: pop the FIFO if the head was used, else bump pointer += 1. used_count += 1.
- Free: free_ready=1 whenever not in reset. A legal free is free_valid && free_ready && free_addr < NODE_COUNT && used_count > 0. It pushes free_addr into the FIFO and decrements used_count.
- Illegal free (addr >= NODE_COUNT, or used_count==0 with no same-cycle allocation): dropped, error <= 1, counters unchanged.
- Recycle latency: a freed address reaches the FIFO head 1 cycle after its free handshake. There is no same-cycle bypass to req_addr.
- Simultaneous allocation and legal free: both take effect; used_count unchanged.
  - If the FIFO was empty, allocation uses the bump pointer and the freed address lands in the FIFO.
  - If the FIFO was non-empty, pop and push occur together and depth is unchanged.
- FIFO depth NODE_COUNT, which cannot overflow for legal traffic. Pointers wrap modulo NODE_COUNT (non-power-of-2 supported via compare-and-clear).
- Bump pointer is RAM_ADDR_WIDTH+1 bits; it saturates at NODE_COUNT and is never decremented.
- full and almost_full are registered, derived from next-state used_count, with the same timing as used_count.
- Double-free of the same address is not detected; this is the caller's responsibility.

Decomposition:
- Package tree_space_pkg:
  - localparam ROOT_ADDR = 0
  - function for counter width (clog2(NODE_COUNT+1))
  - typedef for node address (logic [RAM_ADDR_WIDTH-1:0])
- Sub-module tsa_free_fifo: synchronous FWFT FIFO with registered head.
  - Ports: push/push_data, pop, head, empty, count.
  - Parameters: WIDTH, DEPTH.
  - Async active-high reset.

Test Plan:
- Reset release, NODE_COUNT=4, req_valid held 1:
  - Expected addresses 0,1,2,3 on consecutive cycles.
  - Then req_ready=0, full=1, used_count=4.
  - almost_full=1 from used_count=2 onward.
- From full, free addr 2 at cycle T:
  - req_ready=1 with req_addr=2 at T+1.
  - Allocate it: full=1 again, bump pointer still 4.
- Simultaneous allocation and free, used_count=2, FIFO empty:
  - used_count stays 2; allocated addr = bump value.
  - Freed addr appears at head the next cycle.
- Free addr 7 with NODE_COUNT=4, then free any address with used_count=0:
  - Both dropped; error=1 and stays 1.
  - used_count unchanged.
- Assert areset mid-sequence (used_count=3, FIFO holding 1):
  - All outputs return to reset values asynchronously.
  - First allocation after release returns 0.
- Random alloc/free stress, 10k cycles, NODE_COUNT=5:
  - Scoreboard: no address allocated twice while held.
  - used_count matches the model.
  - Never more than 5 addresses outstanding.
